// File: rtl/ahb_arbiter.sv
// rtl/ahb_arbiter.sv - round-robin AHB arbiter with fixed-burst tracking.
// Optional locked sequences are enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [2:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR = 3'b001;
  localparam logic [2:0] DEF_IDX   = 3'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_BURST = 2'd1,
    ST_INCR  = 2'd2
`ifdef AHB_ARB_LOCK_EN
    , ST_LOCK = 2'd3
`endif
  } state_t;

  state_t                 state, state_nxt;
  logic [4:0]             beat_cnt, beat_cnt_nxt;
  logic [2:0]             grant_idx, grant_idx_nxt;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [2:0]             master_nxt;
  logic [7:0]             req_pad;
  logic                   acc_nonseq, acc_seq, owner_req;
  logic [4:0]             burst_len_m1;
  logic [2:0]             arb_idx;

  // Requests padded to 8 so any 3-bit owner index is safe to look up.
  assign req_pad    = 8'(hbusreq);
  assign acc_nonseq = hready && (htrans == TR_NONSEQ);
  assign acc_seq    = hready && (htrans == TR_SEQ);
  assign owner_req  = req_pad[hmaster];

  always_comb begin
    case (hburst[2:1])
      2'b01:   burst_len_m1 = 5'd3;
      2'b10:   burst_len_m1 = 5'd7;
      2'b11:   burst_len_m1 = 5'd15;
      default: burst_len_m1 = 5'd0;
    endcase
  end

`ifdef AHB_ARB_LOCK_EN
  logic [7:0] lock_pad;
  logic       owner_lock;
  logic       mastlock_q, mastlock_nxt;

  assign lock_pad   = 8'(hlock);
  assign owner_lock = lock_pad[hmaster];
  assign hmastlock  = mastlock_q;
`else
  logic unused_lock;

  assign unused_lock = ^hlock;
  assign hmastlock   = 1'b0;
`endif

  // Round-robin search from the owner's successor; the owner is visited last.
  always_comb begin : p_arb
    int   cand;
    logic found;
    arb_idx = DEF_IDX;
    found   = 1'b0;
    cand    = 0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      cand = int'(hmaster) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && req_pad[cand[2:0]]) begin
        found   = 1'b1;
        arb_idx = cand[2:0];
      end
    end
  end

  always_comb begin : p_next
    state_nxt     = state;
    beat_cnt_nxt  = beat_cnt;
    grant_idx_nxt = grant_idx;
    grant_nxt     = hgrant;
    master_nxt    = hmaster;
`ifdef AHB_ARB_LOCK_EN
    mastlock_nxt  = mastlock_q;
`endif
    if (hready) begin
      master_nxt = grant_idx;
`ifdef AHB_ARB_LOCK_EN
      mastlock_nxt = lock_pad[grant_idx];
`endif
      if (acc_nonseq) begin
        beat_cnt_nxt = burst_len_m1;
      end else if (acc_seq && (beat_cnt != 5'd0)) begin
        beat_cnt_nxt = beat_cnt - 5'd1;
      end

      // State follows the accepted transfer, independent of who wins the grant.
      case (state)
        ST_ARB: begin
          if (acc_nonseq) begin
            if (burst_len_m1 != 5'd0)      state_nxt = ST_BURST;
            else if (hburst == BURST_INCR) state_nxt = ST_INCR;
            else                           state_nxt = ST_ARB;
          end
        end
        ST_BURST: begin
          if (acc_nonseq) begin
            if (burst_len_m1 != 5'd0)      state_nxt = ST_BURST;
            else if (hburst == BURST_INCR) state_nxt = ST_INCR;
            else                           state_nxt = ST_ARB;
          end else if (acc_seq && (beat_cnt == 5'd1)) begin
            state_nxt = ST_ARB;
          end
        end
        ST_INCR: begin
          if (acc_nonseq) begin
            state_nxt = (burst_len_m1 != 5'd0) ? ST_BURST : ST_ARB;
          end else if (!owner_req || (htrans == TR_IDLE)) begin
            state_nxt = ST_ARB;
          end
        end
`ifdef AHB_ARB_LOCK_EN
        ST_LOCK: begin
          if (!owner_lock && (beat_cnt == 5'd0)) state_nxt = ST_ARB;
        end
`endif
        default: state_nxt = ST_ARB;
      endcase

`ifdef AHB_ARB_LOCK_EN
      if (acc_nonseq && owner_req && owner_lock) state_nxt = ST_LOCK;
`endif

      if (state_nxt == ST_ARB) begin
        grant_idx_nxt = arb_idx;
        grant_nxt     = NUM_MASTERS'(1) << arb_idx;
      end
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state      <= ST_ARB;
      beat_cnt   <= 5'd0;
      grant_idx  <= DEF_IDX;
      hgrant     <= DEF_GRANT;
      hmaster    <= DEF_IDX;
`ifdef AHB_ARB_LOCK_EN
      mastlock_q <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      beat_cnt   <= beat_cnt_nxt;
      grant_idx  <= grant_idx_nxt;
      hgrant     <= grant_nxt;
      hmaster    <= master_nxt;
`ifdef AHB_ARB_LOCK_EN
      mastlock_q <= mastlock_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_ahb_arbiter.sv
// tb/tb_ahb_arbiter.sv - directed self-checking bench for ahb_arbiter.
// Lock scenario compiles in when AHB_ARB_LOCK_EN is defined.
module tb_ahb_arbiter;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic       hclk;
  logic       hresetn;
  logic [3:0] hbusreq;
  logic [3:0] hlock;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [2:0] hmaster;
  logic       hmastlock;

  int n_cmp;
  int n_fail;

  ahb_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .hclk(hclk), .hresetn(hresetn), .hbusreq(hbusreq), .hlock(hlock),
    .htrans(htrans), .hburst(hburst), .hready(hready),
    .hgrant(hgrant), .hmaster(hmaster), .hmastlock(hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic do_reset();
    hbusreq = 4'b0000; hlock = 4'b0000; htrans = IDLE; hburst = 3'b000; hready = 1'b1;
    hresetn = 1'b0;
    step();
    hresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    hresetn = 1'b0;
    step();
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL reset_grant: got %b want 0001", hgrant); end
    n_cmp++; if (hmaster !== 3'd0) begin n_fail++; $display("FAIL reset_master: got %0d want 0", hmaster); end
    n_cmp++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL reset_mastlock: got %b want 0", hmastlock); end
    hresetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL idle_grant[%0d]: got %b want 0001", k, hgrant); end
      n_cmp++; if (hmaster !== 3'd0) begin n_fail++; $display("FAIL idle_master[%0d]: got %0d want 0", k, hmaster); end
      n_cmp++; if (dut.beat_cnt !== 5'd0) begin n_fail++; $display("FAIL idle_cnt[%0d]: got %0d want 0", k, dut.beat_cnt); end
    end
  endtask

  task automatic test_round_robin();
    int exp_g[8] = '{1, 1, 2, 2, 3, 3, 1, 1};
    int exp_m[8] = '{0, 1, 1, 2, 2, 3, 3, 1};
    logic [3:0] eg;
    do_reset();
    hbusreq = 4'b1110; htrans = NONSEQ; hburst = 3'b000;
    for (int k = 0; k < 8; k++) begin
      step();
      eg = 4'b0001 << exp_g[k];
      n_cmp++; if (hgrant !== eg) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", k, hgrant, eg); end
      n_cmp++; if (hmaster !== 3'(exp_m[k])) begin n_fail++; $display("FAIL rr_master[%0d]: got %0d want %0d", k, hmaster, exp_m[k]); end
    end
    htrans = IDLE;
  endtask

  task automatic test_burst_frozen();
    do_reset();
    hbusreq = 4'b0100;
    step();
    n_cmp++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL bf_grant_req: got %b want 0100", hgrant); end
    step();
    n_cmp++; if (hmaster !== 3'd2) begin n_fail++; $display("FAIL bf_owner: got %0d want 2", hmaster); end
    htrans = NONSEQ; hburst = 3'b101;
    step();
    n_cmp++; if (dut.beat_cnt !== 5'd7) begin n_fail++; $display("FAIL bf_load: got %0d want 7", dut.beat_cnt); end
    for (int b = 2; b <= 8; b++) begin
      htrans = SEQ;
      if (b == 2) hbusreq = 4'b1100;
      step();
      n_cmp++; if (dut.beat_cnt !== 5'(8 - b)) begin n_fail++; $display("FAIL bf_cnt[%0d]: got %0d want %0d", b, dut.beat_cnt, 8 - b); end
      if (b < 8) begin
        n_cmp++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL bf_hold[%0d]: got %b want 0100", b, hgrant); end
      end else begin
        n_cmp++; if (hgrant !== 4'b1000) begin n_fail++; $display("FAIL bf_last: got %b want 1000", hgrant); end
      end
    end
    htrans = IDLE;
    step();
    n_cmp++; if (hmaster !== 3'd3) begin n_fail++; $display("FAIL bf_next_owner: got %0d want 3", hmaster); end
  endtask

  task automatic test_wait_states();
    do_reset();
    hbusreq = 4'b0010;
    step(); step();
    htrans = NONSEQ; hburst = 3'b011;
    step();
    hbusreq = 4'b0011; htrans = SEQ;
    step();
    n_cmp++; if (dut.beat_cnt !== 5'd2) begin n_fail++; $display("FAIL ws_cnt_b2: got %0d want 2", dut.beat_cnt); end
    hready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++; if (dut.beat_cnt !== 5'd2) begin n_fail++; $display("FAIL ws_cnt_hold[%0d]: got %0d want 2", k, dut.beat_cnt); end
      n_cmp++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL ws_grant_hold[%0d]: got %b want 0010", k, hgrant); end
      n_cmp++; if (hmaster !== 3'd1) begin n_fail++; $display("FAIL ws_master_hold[%0d]: got %0d want 1", k, hmaster); end
    end
    hready = 1'b1;
    step();
    n_cmp++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL ws_grant_b3: got %b want 0010", hgrant); end
    step();
    n_cmp++; if (dut.beat_cnt !== 5'd0) begin n_fail++; $display("FAIL ws_cnt_end: got %0d want 0", dut.beat_cnt); end
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL ws_grant_end: got %b want 0001", hgrant); end
    htrans = IDLE;
  endtask

  task automatic test_incr();
    do_reset();
    hbusreq = 4'b0010;
    step(); step();
    htrans = NONSEQ; hburst = 3'b001;
    step();
    hbusreq = 4'b0110; htrans = SEQ;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL incr_hold[%0d]: got %b want 0010", k, hgrant); end
    end
    hbusreq = 4'b0100;
    step();
    n_cmp++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL incr_release: got %b want 0100", hgrant); end
    htrans = IDLE;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    hbusreq = 4'b0010;
    step(); step();
    htrans = NONSEQ; hburst = 3'b110;
    step();
    htrans = SEQ;
    step();
    n_cmp++; if (dut.beat_cnt !== 5'd14) begin n_fail++; $display("FAIL rmb_cnt: got %0d want 14", dut.beat_cnt); end
    n_cmp++; if (hgrant !== 4'b0010) begin n_fail++; $display("FAIL rmb_grant_pre: got %b want 0010", hgrant); end
    #3;
    hresetn = 1'b0;
    #1;
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL rmb_grant: got %b want 0001", hgrant); end
    n_cmp++; if (hmaster !== 3'd0) begin n_fail++; $display("FAIL rmb_master: got %0d want 0", hmaster); end
    n_cmp++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL rmb_mastlock: got %b want 0", hmastlock); end
    n_cmp++; if (dut.beat_cnt !== 5'd0) begin n_fail++; $display("FAIL rmb_cnt_clr: got %0d want 0", dut.beat_cnt); end
    hbusreq = 4'b0100; htrans = IDLE;
    step();
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL rmb_in_reset: got %b want 0001", hgrant); end
    hresetn = 1'b1;
    step();
    n_cmp++; if (hgrant !== 4'b0100) begin n_fail++; $display("FAIL rmb_first_arb: got %b want 0100", hgrant); end
  endtask

`ifdef AHB_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    hbusreq = 4'b1000; hlock = 4'b1000;
    step(); step();
    n_cmp++; if (hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_mastlock_init: got %b want 1", hmastlock); end
    hbusreq = 4'b1111; hburst = 3'b011;
    for (int b = 0; b < 8; b++) begin
      htrans = ((b % 4) == 0) ? NONSEQ : SEQ;
      step();
      n_cmp++; if (hgrant !== 4'b1000) begin n_fail++; $display("FAIL lock_grant[%0d]: got %b want 1000", b, hgrant); end
      n_cmp++; if (hmastlock !== 1'b1) begin n_fail++; $display("FAIL lock_mastlock[%0d]: got %b want 1", b, hmastlock); end
    end
    hlock = 4'b0000; htrans = IDLE;
    step();
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL lock_release: got %b want 0001", hgrant); end
  endtask
`else
  task automatic test_lock_ignored();
    do_reset();
    hbusreq = 4'b1000; hlock = 4'b1000;
    step(); step();
    hburst = 3'b011; htrans = NONSEQ;
    step();
    hbusreq = 4'b1001; htrans = SEQ;
    for (int b = 1; b < 4; b++) begin
      step();
      n_cmp++; if (hmastlock !== 1'b0) begin n_fail++; $display("FAIL nolock_mastlock[%0d]: got %b want 0", b, hmastlock); end
    end
    n_cmp++; if (hgrant !== 4'b0001) begin n_fail++; $display("FAIL nolock_regrant: got %b want 0001", hgrant); end
    htrans = IDLE; hlock = 4'b0000;
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_round_robin();
    test_burst_frozen();
    test_wait_states();
    test_incr();
    test_reset_mid_burst();
`ifdef AHB_ARB_LOCK_EN
    test_lock();
`else
    test_lock_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
